// File: rtl/mmio_initiator.sv
// LSU-to-peripheral strobe bus initiator: one outstanding word load/store.
// Optional MMIO_POSTED_WRITE_EN: stores complete without a response.
module mmio_initiator #(
  parameter logic [31:0] BASEADDRESS  = 32'h8000_0000,
  parameter logic [31:0] NOREGISTERS  = 32'h0000_0002,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        ACLK,
  input  logic        RESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WRITE,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERROR,
  output logic [31:0] ADDR,
  output logic [31:0] DATA_O,
  input  logic [31:0] DATA_I,
  output logic        WRSTB,
  output logic        RDSTB
);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0]  LAT = 4'(READ_LATENCY);
  localparam logic [32:0] LO  = {1'b0, BASEADDRESS};
  localparam logic [32:0] HI  = {1'b0, BASEADDRESS} + {1'b0, NOREGISTERS};

  state_t     state;
  logic       is_write;
  logic [3:0] cnt;
  logic       in_win;

  // 33-bit compare so the window end cannot wrap
  assign in_win = ({1'b0, REQ_ADDR} >= LO) && ({1'b0, REQ_ADDR} < HI);

  always_ff @(posedge ACLK) begin
    if (!RESET) begin
      state     <= IDLE;
      REQ_READY <= 1'b1;
      is_write  <= 1'b0;
      cnt       <= 4'd0;
      ADDR      <= 32'd0;
      DATA_O    <= 32'd0;
      RSP_RDATA <= 32'd0;
      RSP_ERROR <= 1'b0;
      RSP_VALID <= 1'b0;
      WRSTB     <= 1'b0;
      RDSTB     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (REQ_VALID) begin
            is_write <= REQ_WRITE;
            if (in_win) begin
              ADDR <= REQ_ADDR;
              if (REQ_WRITE)
                DATA_O <= REQ_WDATA;
              WRSTB     <= REQ_WRITE;
              RDSTB     <= !REQ_WRITE;
              REQ_READY <= 1'b0;
              state     <= STROBE;
            end else begin
`ifdef MMIO_POSTED_WRITE_EN
              if (!REQ_WRITE) begin
                RSP_ERROR <= 1'b1;
                RSP_RDATA <= 32'd0;
                RSP_VALID <= 1'b1;
                REQ_READY <= 1'b0;
                state     <= RESP;
              end
`else
              RSP_ERROR <= 1'b1;
              RSP_RDATA <= 32'd0;
              RSP_VALID <= 1'b1;
              REQ_READY <= 1'b0;
              state     <= RESP;
`endif
            end
          end
        end
        STROBE: begin
          WRSTB <= 1'b0;
          RDSTB <= 1'b0;
          if (is_write) begin
`ifdef MMIO_POSTED_WRITE_EN
            REQ_READY <= 1'b1;
            state     <= IDLE;
`else
            RSP_ERROR <= 1'b0;
            RSP_RDATA <= 32'd0;
            RSP_VALID <= 1'b1;
            state     <= RESP;
`endif
          end else begin
            cnt   <= LAT;
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            RSP_RDATA <= DATA_I;
            RSP_ERROR <= 1'b0;
            RSP_VALID <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            REQ_READY <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          REQ_READY <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/mmio_initiator.md
Name: mmio_initiator

Overview:
- Bus initiator for the memory-mapped peripheral strobe interface (ADDR / DATA_O / DATA_I / WRSTB / RDSTB) used by the GPIO and other slaves.
- Accepts word load/store requests from the core LSU over a valid/ready channel and issues single-cycle strobes to the peripheral.
- For reads, waits a fixed slave latency, captures DATA_I and returns a response over a valid/ready channel.
- Rejects addresses outside the configured window without strobing.

Parameters:
- BASEADDRESS, 32'h8000_0000, first byte address of the peripheral window.
- NOREGISTERS, 32'h0000_0002, window span in address units; in-window means BASEADDRESS <= addr < BASEADDRESS+NOREGISTERS.
- READ_LATENCY, 1, cycles after the RDSTB cycle at whose end DATA_I is captured; legal range 1..15.

Ports:
- ACLK  input  1  clock; all logic on rising edge.
- RESET  input  1  synchronous, active-low reset (0 = reset).
- REQ_VALID  input  1  request valid.
- REQ_READY  output  1  request accepted when REQ_VALID & REQ_READY.
- REQ_WRITE  input  1  1 = store, 0 = load.
- REQ_ADDR  input  32  byte address.
- REQ_WDATA  input  32  store data.
- RSP_VALID  output  1  response valid.
- RSP_READY  input  1  response consumed when RSP_VALID & RSP_READY.
- RSP_RDATA  output  32  load data; 0 for stores and errors.
- RSP_ERROR  output  1  1 = address outside window.
- ADDR  output  32  peripheral address.
- DATA_O  output  32  peripheral write data.
- DATA_I  input  32  peripheral read data.
- WRSTB  output  1  peripheral write strobe.
- RDSTB  output  1  peripheral read strobe.

Behaviour:
- Reset (RESET=0 at an edge): state IDLE. ADDR, DATA_O, RSP_RDATA, wait counter = 0. WRSTB, RDSTB, RSP_VALID, RSP_ERROR = 0. Reset mid-transaction aborts it: no response, strobes drop at that edge.
- States:
  - IDLE: REQ_READY=1, driven from state only, no combinational path from REQ_VALID. All other states: REQ_READY=0.
    - Accept, in-window: register ADDR<=REQ_ADDR; for writes also DATA_O<=REQ_WDATA. Go to STROBE.
    - Accept, out-of-window: RSP_ERROR<=1, RSP_RDATA<=0. Go to RESP. ADDR, DATA_O and strobes are untouched.
  - STROBE: exactly one cycle, WRSTB=1 (write) or RDSTB=1 (read), never both.
    - Write: go to RESP with RSP_ERROR=0, RSP_RDATA=0.
    - Read: load counter with READ_LATENCY and go to WAIT.
  - WAIT: decrement the counter each cycle. At the edge where counter==1: RSP_RDATA<=DATA_I, RSP_ERROR<=0, go to RESP.
  - RESP: RSP_VALID=1. RSP_RDATA and RSP_ERROR are held stable until RSP_READY=1 at an edge, then go to IDLE.
- Window compare is done in 33 bits so BASEADDRESS+NOREGISTERS cannot wrap. No alignment check.
- ADDR and DATA_O hold their values after the transaction until the next in-window accept.
- Latency from accept edge (E) to RSP_VALID:
  - Read: RSP_VALID from cycle E+2+READ_LATENCY (E+3 at default).
  - Write: RSP_VALID from cycle E+2.
  - Error: RSP_VALID from cycle E+1.
- Throughput: one outstanding request. The next accept is possible in the cycle after the response handshake.
- RSP_READY held high in RESP completes in one cycle. RSP_READY low stalls indefinitely with no strobes issued.

Optional Feature:
- Macro: MMIO_POSTED_WRITE_EN.
- Defined:
  - In-window writes generate no response. After STROBE the block returns directly to IDLE, so writes occupy 2 cycles (accept and strobe).
  - Out-of-window writes are silently dropped: no strobe, no response, straight back to IDLE.
  - Reads are unchanged.
- Undefined: every request gets exactly one response, as described under Behaviour.

Test Plan:
- Write in-window: write 0x8000_0000 data 0x0000_01FF -> one WRSTB cycle with ADDR=0x8000_0000, DATA_O=0x0000_01FF. Response RSP_VALID at E+2, RSP_ERROR=0, RSP_RDATA=0.
- Read in-window: slave model returns 0xDEAD_BEEF one cycle after RDSTB, read 0x8000_0001 -> one RDSTB cycle; RSP_RDATA=0xDEAD_BEEF at E+3, RSP_ERROR=0.
- Out-of-window: read 0x8000_0002, then write 0x7FFF_FFFF -> no strobes; each gives RSP_VALID at E+1 with RSP_ERROR=1, RSP_RDATA=0; ADDR keeps its prior value.
- Backpressure: RSP_READY=0 for 5 cycles after RSP_VALID -> RSP_RDATA and RSP_ERROR stable, REQ_READY=0, no strobes; release gives IDLE next cycle.
- Reset: RESET=0 during WAIT of a read -> next cycle all outputs at reset values, no response; a new read after release completes normally.
- Latency and feature: READ_LATENCY=3 read captures DATA_I at the end of cycle S+3. With MMIO_POSTED_WRITE_EN defined, back-to-back writes strobe every 2 cycles and RSP_VALID never asserts.
